nwr_req_gen: RTL and testbench

- Downstream neighbour of the user-data input reader.
- Consumes its packetised 64-bit stream: at most 256 B per packet, with tfirst, tlast and done markers plus an 8-bit length (bytes-1).
- Emits SRIO NWRITE requests on the ireq AXI4-Stream port of the SRIO core, in HELLO format: one header beat followed by the payload beats.
- Generates the per-packet target address (base + 256 per packet) and the transaction ID, and reports completion and length-mismatch status.

---
 rtl/nwr_req_gen.sv | 132 +++++++++++++
 tb/tb_nwr_req_gen.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nwr_req_gen.sv
// rtl/nwr_req_gen.sv - SRIO NWRITE request generator: HELLO header beat plus payload pass-through
module nwr_req_gen #(
  parameter int          DATA_WIDTH = 64,
  parameter int          ADDR_WIDTH = 34,
  parameter logic [15:0] SRC_ID     = 16'h00F0,
  parameter logic [15:0] DEST_ID    = 16'h00FF,
  parameter logic [1:0]  PRIO       = 2'b01
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   cfg_base_addr,
  input  logic [DATA_WIDTH-1:0]   in_tdata,
  input  logic                    in_tvalid,
  input  logic [DATA_WIDTH/8-1:0] in_tkeep,
  input  logic                    in_tfirst,
  input  logic                    in_tlast,
  input  logic [7:0]              in_data_len,
  input  logic                    in_done,
  output logic                    in_tready,
  output logic [DATA_WIDTH-1:0]   ireq_tdata,
  output logic                    ireq_tvalid,
  input  logic                    ireq_tready,
  output logic [DATA_WIDTH/8-1:0] ireq_tkeep,
  output logic                    ireq_tlast,
  output logic [31:0]             ireq_tuser,
  output logic [15:0]             pkt_count,
  output logic                    busy,
  output logic                    xfer_done,
  output logic                    len_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_t;

  state_t                state;
  logic [7:0]            tid;
  logic [7:0]            len;
  logic [7:0]            beat_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  first_pkt;
  logic [33:0]           hdr_addr;
  logic [63:0]           header;
  logic                  data_hs;
  logic [8:0]            beats_seen;
  logic [8:0]            beats_exp;

  assign hdr_addr   = 34'(addr);
  assign header     = {tid, 4'h5, 4'h4, 1'b0, PRIO, 1'b0, len, 2'b00, hdr_addr};
  assign data_hs    = (state == DATA) && in_tvalid && ireq_tready;
  assign beats_seen = {1'b0, beat_cnt} + 9'd1;
  assign beats_exp  = {4'd0, len[7:3]} + 9'd1;

  assign busy       = (state != IDLE);
  assign ireq_tuser = {SRC_ID, DEST_ID};

  // Header comes from registers only, so it holds under backpressure; DATA is a wire path.
  always_comb begin
    in_tready   = 1'b0;
    ireq_tvalid = 1'b0;
    ireq_tdata  = '0;
    ireq_tkeep  = '0;
    ireq_tlast  = 1'b0;
    case (state)
      HDR: begin
        ireq_tvalid = 1'b1;
        ireq_tdata  = DATA_WIDTH'(header);
        ireq_tkeep  = '1;
      end
      DATA: begin
        ireq_tvalid = in_tvalid;
        ireq_tdata  = in_tdata;
        ireq_tkeep  = in_tkeep;
        ireq_tlast  = in_tlast;
        in_tready   = ireq_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    xfer_done <= 1'b0;
    if (!reset) begin
      state     <= IDLE;
      tid       <= '0;
      len       <= '0;
      beat_cnt  <= '0;
      addr      <= '0;
      first_pkt <= 1'b1;
      pkt_count <= '0;
      len_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_tvalid && in_tfirst) begin
            len <= in_data_len;
            if (first_pkt) begin
              addr      <= cfg_base_addr;
              first_pkt <= 1'b0;
            end
            state <= HDR;
          end
        end
        HDR: begin
          if (ireq_tready) begin
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (data_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (in_tlast) begin
              tid  <= tid + 8'd1;
              addr <= addr + ADDR_WIDTH'(256);
              if (beats_seen != beats_exp) len_err <= 1'b1;
              // The bus still carries the tlast beat here; the next tfirst is picked up from IDLE.
              state <= IDLE;
              if (in_done) begin
                xfer_done <= 1'b1;
                pkt_count <= '0;
                first_pkt <= 1'b1;
              end else begin
                pkt_count <= pkt_count + 16'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nwr_req_gen.sv
// tb/tb_nwr_req_gen.sv - self-checking bench for nwr_req_gen: vector table, random stalls, packet-level scoreboard
`timescale 1ns/1ps
module tb_nwr_req_gen;
  localparam int AW = 34;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cfg_base_addr;
  logic [63:0]   in_tdata;
  logic          in_tvalid;
  logic [7:0]    in_tkeep;
  logic          in_tfirst;
  logic          in_tlast;
  logic [7:0]    in_data_len;
  logic          in_done;
  logic          in_tready;
  logic [63:0]   ireq_tdata;
  logic          ireq_tvalid;
  logic          ireq_tready;
  logic [7:0]    ireq_tkeep;
  logic          ireq_tlast;
  logic [31:0]   ireq_tuser;
  logic [15:0]   pkt_count;
  logic          busy;
  logic          xfer_done;
  logic          len_err;

  always #5 clk = ~clk;

  nwr_req_gen dut (
    .clk(clk), .reset(reset), .cfg_base_addr(cfg_base_addr),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tkeep(in_tkeep),
    .in_tfirst(in_tfirst), .in_tlast(in_tlast), .in_data_len(in_data_len),
    .in_done(in_done), .in_tready(in_tready),
    .ireq_tdata(ireq_tdata), .ireq_tvalid(ireq_tvalid), .ireq_tready(ireq_tready),
    .ireq_tkeep(ireq_tkeep), .ireq_tlast(ireq_tlast), .ireq_tuser(ireq_tuser),
    .pkt_count(pkt_count), .busy(busy), .xfer_done(xfer_done), .len_err(len_err)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [7:0]    len;
    int            beats;
    logic [63:0]   hdr;
  } vec_t;

  int errors = 0;
  int checks = 0;

  beat_t         exp_q[$];
  int            m_tid;
  int            m_idx;
  bit            m_first;
  bit            m_len_err;
  logic [AW-1:0] m_base;
  bit            rand_ready;
  logic [63:0]   last_hdr;
  int            last_payload;
  int            cur_payload;
  bit            hdr_next;
  int            xfer_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_hdr(input int tid, input logic [7:0] len, input logic [AW-1:0] a);
    return (64'(tid % 256) << 56) | (64'h5 << 52) | (64'h4 << 48) | (64'h1 << 45)
         | (64'(len) << 36) | 64'(a);
  endfunction

  task automatic monitor();
    bit    stall_prev = 0;
    beat_t sb;
    beat_t b;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_prev = 0;
        hdr_next   = 1;
      end else begin
        if (stall_prev) begin
          check("stall_valid", 64'(ireq_tvalid), 64'd1);
          check("stall_data", ireq_tdata, sb.data);
          check("stall_keep", 64'(ireq_tkeep), 64'(sb.keep));
          check("stall_last", 64'(ireq_tlast), 64'(sb.last));
        end
        if (xfer_done === 1'b1) xfer_seen++;
        if (ireq_tvalid === 1'b1 && ireq_tready === 1'b1) begin
          check("tuser", 64'(ireq_tuser), 64'h00F0_00FF);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h expected no beat", ireq_tdata);
          end else begin
            b = exp_q.pop_front();
            check("beat_data", ireq_tdata, b.data);
            check("beat_keep", 64'(ireq_tkeep), 64'(b.keep));
            check("beat_last", 64'(ireq_tlast), 64'(b.last));
          end
          if (hdr_next) begin
            last_hdr    = ireq_tdata;
            cur_payload = 0;
            hdr_next    = 0;
          end else begin
            cur_payload++;
            if (ireq_tlast) begin
              last_payload = cur_payload;
              hdr_next     = 1;
            end
          end
        end
        stall_prev = (ireq_tvalid === 1'b1) && (ireq_tready !== 1'b1);
        sb = '{ireq_tdata, ireq_tkeep, ireq_tlast};
      end
    end
  endtask

  task automatic ready_gen();
    forever begin
      @(posedge clk);
      #1;
      ireq_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic model_reset();
    m_tid     = 0;
    m_idx     = 0;
    m_first   = 1;
    m_len_err = 0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    in_tvalid = 1'b0;
    in_tfirst = 1'b0;
    in_tlast  = 1'b0;
    in_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // abort_after >= 0 pulls reset after that many payload handshakes
  task automatic send_pkt(input logic [7:0] len, input int nbeats, input bit done,
                          input int abort_after, input bit gaps);
    logic [AW-1:0] a;
    beat_t         b;
    bit            hs;
    int            cnt;
    if (m_first) begin
      m_base  = cfg_base_addr;
      m_idx   = 0;
      m_first = 0;
    end
    a = m_base + AW'(m_idx * 256);
    exp_q.push_back('{model_hdr(m_tid, len, a), 8'hFF, 1'b0});
    for (int i = 0; i < nbeats; i++) begin
      if (i == abort_after) begin
        reset     = 1'b0;
        in_tvalid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_tvalid", 64'(ireq_tvalid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_pkt_count", 64'(pkt_count), 64'd0);
        reset = 1'b1;
        model_reset();
        in_tfirst = 1'b0;
        in_tlast  = 1'b0;
        in_done   = 1'b0;
        return;
      end
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      b = '{{$urandom, $urandom}, 8'($urandom), (i == nbeats - 1)};
      exp_q.push_back(b);
      in_tvalid   = 1'b1;
      in_tdata    = b.data;
      in_tkeep    = b.keep;
      in_tfirst   = (i == 0);
      in_tlast    = b.last;
      in_data_len = len;
      in_done     = b.last ? done : (gaps && $urandom_range(0, 3) == 0);
      hs  = 0;
      cnt = 0;
      while (!hs && cnt < 2000) begin
        @(negedge clk);
        hs = (in_tready === 1'b1);
        @(posedge clk);
        #1;
        cnt++;
      end
      if (!hs) begin
        checks++;
        errors++;
        $display("FAIL in_handshake_timeout: got no in_tready expected handshake within 2000 cycles");
      end
    end
    in_tvalid = 1'b0;
    in_tfirst = 1'b0;
    in_tlast  = 1'b0;
    in_done   = 1'b0;
    if (nbeats != int'(len) / 8 + 1) m_len_err = 1;
    m_tid++;
    m_idx++;
    if (done) begin
      m_first = 1;
      check("xfer_done_pulse", 64'(xfer_done), 64'd1);
      check("pkt_count_clear", 64'(pkt_count), 64'd0);
      check("len_err_state", 64'(len_err), 64'(m_len_err));
    end else begin
      check("pkt_count", 64'(pkt_count), 64'(m_idx));
    end
  endtask

  task automatic drain();
    int cnt = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && cnt < 3000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    vec_t tbl[4];
    int   xs;
    int   np;
    tbl[0] = '{34'h1_0000_0000, 8'h0F,  2, 64'h0054_20F1_0000_0000};
    tbl[1] = '{34'h0_0000_1000, 8'h07,  1, 64'h0154_2070_0000_1000};
    tbl[2] = '{34'h3_FFFF_FF00, 8'hFF, 32, 64'h0254_2FF3_FFFF_FF00};
    tbl[3] = '{34'h2_0000_0000, 8'h10,  3, 64'h0354_2102_0000_0000};

    reset         = 1'b0;
    ireq_tready   = 1'b1;
    rand_ready    = 0;
    cfg_base_addr = '0;
    in_tdata      = '0;
    in_tkeep      = '0;
    in_data_len   = '0;
    in_tvalid     = 1'b0;
    in_tfirst     = 1'b0;
    in_tlast      = 1'b0;
    in_done       = 1'b0;
    hdr_next      = 1;
    xfer_seen     = 0;
    last_hdr      = '0;
    last_payload  = 0;
    cur_payload   = 0;
    model_reset();
    fork
      monitor();
      ready_gen();
    join_none

    apply_reset();
    check("rst_tvalid", 64'(ireq_tvalid), 64'd0);
    check("rst_tdata", ireq_tdata, 64'd0);
    check("rst_tkeep", 64'(ireq_tkeep), 64'd0);
    check("rst_tlast", 64'(ireq_tlast), 64'd0);
    check("rst_in_tready", 64'(in_tready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_xfer_done", 64'(xfer_done), 64'd0);
    check("rst_len_err", 64'(len_err), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);

    for (int i = 0; i < 4; i++) begin
      cfg_base_addr = tbl[i].base;
      send_pkt(tbl[i].len, tbl[i].beats, 1'b1, -1, 1'b0);
      drain();
      check($sformatf("tbl%0d_hdr", i), last_hdr, tbl[i].hdr);
      check($sformatf("tbl%0d_beats", i), 64'(last_payload), 64'(tbl[i].beats));
    end

    // Stray data without tfirst in IDLE must be held off
    in_tvalid = 1'b1;
    in_tfirst = 1'b0;
    in_tdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stray_in_tready", 64'(in_tready), 64'd0);
      check("stray_tvalid", 64'(ireq_tvalid), 64'd0);
      @(posedge clk);
      #1;
    end
    in_tvalid = 1'b0;

    cfg_base_addr = 34'h0_8000_0000;
    xs = xfer_seen;
    send_pkt(8'hFF, 32, 1'b0, -1, 1'b0);
    send_pkt(8'hFF, 32, 1'b0, -1, 1'b0);
    send_pkt(8'h0F, 2, 1'b1, -1, 1'b0);
    drain();
    check("three_pkt_xfer_done_count", 64'(xfer_seen - xs), 64'd1);
    check("three_pkt_last_hdr", last_hdr, 64'h0654_20F0_8000_0200);

    rand_ready = 1;
    for (int t = 0; t < 20; t++) begin
      logic [7:0] l;
      cfg_base_addr = AW'({$urandom, $urandom});
      np = $urandom_range(1, 4);
      for (int p = 0; p < np; p++) begin
        l = 8'($urandom);
        send_pkt(l, int'(l) / 8 + 1, p == np - 1, -1, 1'b1);
      end
    end
    drain();
    rand_ready = 0;
    check("random_len_err", 64'(len_err), 64'd0);

    apply_reset();
    cfg_base_addr = 34'h1_0000_0000;
    for (int p = 0; p < 257; p++) send_pkt(8'h07, 1, p == 256, -1, 1'b0);
    drain();
    check("wrap_tid", 64'(last_hdr[63:56]), 64'd0);
    check("wrap_addr", 64'(last_hdr[33:0]), 64'h1_0001_0000);

    apply_reset();
    cfg_base_addr = 34'h0_0000_2000;
    send_pkt(8'h1F, 3, 1'b1, -1, 1'b0);
    drain();
    check("short_len_err", 64'(len_err), 64'd1);
    check("short_beats", 64'(last_payload), 64'd3);
    send_pkt(8'h0F, 2, 1'b1, -1, 1'b0);
    drain();
    check("len_err_sticky", 64'(len_err), 64'd1);
    apply_reset();
    check("len_err_cleared", 64'(len_err), 64'd0);

    cfg_base_addr = 34'h2_0000_0000;
    send_pkt(8'hFF, 32, 1'b1, 10, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_quiet", 64'(ireq_tvalid), 64'd0);
    cfg_base_addr = 34'h0_0000_4000;
    send_pkt(8'h0F, 2, 1'b1, -1, 1'b0);
    drain();
    check("post_abort_hdr", last_hdr, 64'h0054_20F0_0000_4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
